// File: rtl/stack_sequencer.sv
// Hardware stack sequencer: pushes return PC (and flags) on CALL/interrupt,
// pops them back on RET/RTI, stalling the pipeline while the stack is busy.
module stack_sequencer #(
  parameter logic [31:0] SP_RESET   = 32'd4095,
  parameter logic [31:0] INT_VECTOR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  input  logic        CALL,
  input  logic        RET,
  input  logic        RTI,
  input  logic [31:0] Target,
  input  logic [31:0] Return_PC,
  input  logic [2:0]  Flags,
  input  logic [15:0] Mem_Data_In,
  output logic [31:0] Mem_Address,
  output logic [15:0] Mem_Data_Out,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Stall,
  output logic        PC_Load,
  output logic [31:0] PC_Out,
  output logic        Flags_Load,
  output logic [2:0]  Flags_Out,
  output logic [31:0] Stack_Pointer_Out
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_F, POP_F, POP_LO, POP_HI, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sp_q, sp_d;
  logic        int_prev_q, int_prev_d;
  logic        int_pend_q, int_pend_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [31:0] target_q, target_d;
  logic [2:0]  flags_q, flags_d;
  logic        is_int_q, is_int_d;
  logic        is_rti_q, is_rti_d;
  logic [15:0] lo_q, lo_d;
  logic [2:0]  pflags_q, pflags_d;

  logic idle, acc_call, acc_ret, acc_rti, acc_int, accept;

  always_comb begin
    idle     = (state_q == IDLE);
    acc_call = idle & CALL;
    acc_ret  = idle & ~CALL & RET;
    acc_rti  = idle & ~CALL & ~RET & RTI;
    acc_int  = idle & ~CALL & ~RET & ~RTI & int_pend_q;
    accept   = acc_call | acc_ret | acc_rti | acc_int;
  end

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    ret_pc_d   = ret_pc_q;
    target_d   = target_q;
    flags_d    = flags_q;
    is_int_d   = is_int_q;
    is_rti_d   = is_rti_q;
    lo_d       = lo_q;
    pflags_d   = pflags_q;
    int_prev_d = INT;
    // an edge arriving on the accept cycle is a new request, so it wins over the clear
    int_pend_d = (int_pend_q & ~acc_int) | (INT & ~int_prev_q);
    case (state_q)
      IDLE: begin
        if (acc_call) begin
          ret_pc_d = Return_PC;
          target_d = Target;
          is_int_d = 1'b0;
          state_d  = PUSH_HI;
        end else if (acc_ret) begin
          is_rti_d = 1'b0;
          state_d  = POP_LO;
        end else if (acc_rti) begin
          is_rti_d = 1'b1;
          state_d  = POP_F;
        end else if (acc_int) begin
          ret_pc_d = Return_PC;
          flags_d  = Flags;
          is_int_d = 1'b1;
          state_d  = PUSH_HI;
        end
      end
      PUSH_HI: begin
        sp_d    = sp_q - 32'd1;
        state_d = PUSH_LO;
      end
      PUSH_LO: begin
        sp_d    = sp_q - 32'd1;
        state_d = is_int_q ? PUSH_F : IDLE;
      end
      PUSH_F: begin
        sp_d    = sp_q - 32'd1;
        state_d = IDLE;
      end
      POP_F: begin
        sp_d    = sp_q + 32'd1;
        state_d = POP_LO;
      end
      POP_LO: begin
        sp_d = sp_q + 32'd1;
        if (is_rti_q) pflags_d = Mem_Data_In[2:0];
        state_d = POP_HI;
      end
      POP_HI: begin
        sp_d    = sp_q + 32'd1;
        lo_d    = Mem_Data_In;
        state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sp_q       <= SP_RESET;
      int_prev_q <= 1'b0;
      int_pend_q <= 1'b0;
      ret_pc_q   <= '0;
      target_q   <= '0;
      flags_q    <= '0;
      is_int_q   <= 1'b0;
      is_rti_q   <= 1'b0;
      lo_q       <= '0;
      pflags_q   <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      int_prev_q <= int_prev_d;
      int_pend_q <= int_pend_d;
      ret_pc_q   <= ret_pc_d;
      target_q   <= target_d;
      flags_q    <= flags_d;
      is_int_q   <= is_int_d;
      is_rti_q   <= is_rti_d;
      lo_q       <= lo_d;
      pflags_q   <= pflags_d;
    end
  end

  // Outputs decode the current state; reset gates them so an aborted
  // sequence issues no further memory access or PC update.
  always_comb begin
    Mem_Address  = '0;
    Mem_Data_Out = '0;
    Mem_Read     = 1'b0;
    Mem_Write    = 1'b0;
    PC_Load      = 1'b0;
    PC_Out       = '0;
    Flags_Load   = 1'b0;
    Flags_Out    = '0;
    Stall        = 1'b0;
    if (!reset) begin
      Stall = ~idle | accept;
      case (state_q)
        PUSH_HI: begin
          Mem_Write    = 1'b1;
          Mem_Address  = sp_q;
          Mem_Data_Out = ret_pc_q[31:16];
        end
        PUSH_LO: begin
          Mem_Write    = 1'b1;
          Mem_Address  = sp_q;
          Mem_Data_Out = ret_pc_q[15:0];
          if (!is_int_q) begin
            PC_Load = 1'b1;
            PC_Out  = target_q;
          end
        end
        PUSH_F: begin
          Mem_Write    = 1'b1;
          Mem_Address  = sp_q;
          Mem_Data_Out = {13'b0, flags_q};
          PC_Load      = 1'b1;
          PC_Out       = INT_VECTOR;
        end
        POP_F, POP_LO, POP_HI: begin
          Mem_Read    = 1'b1;
          Mem_Address = sp_q + 32'd1;
        end
        FINISH: begin
          // hi word arrives this cycle straight from memory
          PC_Load = 1'b1;
          PC_Out  = {Mem_Data_In, lo_q};
          if (is_rti_q) begin
            Flags_Load = 1'b1;
            Flags_Out  = pflags_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign Stack_Pointer_Out = sp_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: expected strobes are queued as
// stimulus is driven and popped by a negedge monitor.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic        INT, CALL, RET, RTI;
  logic [31:0] Target, Return_PC;
  logic [2:0]  Flags;
  logic        sel;

  logic [31:0] addr_a, addr_b, pco_a, pco_b, sp_a, sp_b;
  logic [15:0] dout_a, dout_b;
  logic [15:0] din_a = '0, din_b = '0;
  logic        rd_a, rd_b, wr_a, wr_b, st_a, st_b, pcl_a, pcl_b, fl_a, fl_b;
  logic [2:0]  fo_a, fo_b;

  always #5 clk = ~clk;

  stack_sequencer dut_a (
    .clk(clk), .reset(reset_a), .INT(INT), .CALL(CALL), .RET(RET), .RTI(RTI),
    .Target(Target), .Return_PC(Return_PC), .Flags(Flags), .Mem_Data_In(din_a),
    .Mem_Address(addr_a), .Mem_Data_Out(dout_a), .Mem_Read(rd_a), .Mem_Write(wr_a),
    .Stall(st_a), .PC_Load(pcl_a), .PC_Out(pco_a), .Flags_Load(fl_a),
    .Flags_Out(fo_a), .Stack_Pointer_Out(sp_a));

  stack_sequencer #(.SP_RESET(32'd0), .INT_VECTOR(32'd0)) dut_b (
    .clk(clk), .reset(reset_b), .INT(INT), .CALL(CALL), .RET(RET), .RTI(RTI),
    .Target(Target), .Return_PC(Return_PC), .Flags(Flags), .Mem_Data_In(din_b),
    .Mem_Address(addr_b), .Mem_Data_Out(dout_b), .Mem_Read(rd_b), .Mem_Write(wr_b),
    .Stall(st_b), .PC_Load(pcl_b), .PC_Out(pco_b), .Flags_Load(fl_b),
    .Flags_Out(fo_b), .Stack_Pointer_Out(sp_b));

  // small word memories, one per instance, one-cycle read latency
  logic [15:0] mem_a [16] = '{default: 16'h0};
  logic [15:0] mem_b [16] = '{default: 16'h0};
  always @(posedge clk) begin
    if (wr_a) mem_a[addr_a[3:0]] <= dout_a;
    if (rd_a) din_a <= mem_a[addr_a[3:0]];
    if (wr_b) mem_b[addr_b[3:0]] <= dout_b;
    if (rd_b) din_b <= mem_b[addr_b[3:0]];
  end

  logic [31:0] o_addr, o_pco, o_sp;
  logic [15:0] o_dout;
  logic        o_rd, o_wr, o_st, o_pcl, o_fl;
  logic [2:0]  o_fo;
  assign o_addr = sel ? addr_b : addr_a;
  assign o_dout = sel ? dout_b : dout_a;
  assign o_rd   = sel ? rd_b   : rd_a;
  assign o_wr   = sel ? wr_b   : wr_a;
  assign o_st   = sel ? st_b   : st_a;
  assign o_pcl  = sel ? pcl_b  : pcl_a;
  assign o_pco  = sel ? pco_b  : pco_a;
  assign o_fl   = sel ? fl_b   : fl_a;
  assign o_fo   = sel ? fo_b   : fo_a;
  assign o_sp   = sel ? sp_b   : sp_a;

  localparam int K_WR = 0, K_RD = 1, K_PC = 2, K_FL = 3;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_strobe_kind", k, 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_kind", k, e.kind);
    if (k == K_WR || k == K_RD) chk("sb_addr", a, e.addr);
    if (k != K_RD) chk("sb_data", d, e.data);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (o_wr && o_rd) chk("rd_wr_exclusive", 32'd1, 32'd0);
      if (o_wr) pop_cmp(K_WR, o_addr, {16'h0, o_dout});
      if (o_rd) pop_cmp(K_RD, o_addr, 32'h0);
      if (o_pcl) pop_cmp(K_PC, 32'h0, o_pco);
      if (o_fl) pop_cmp(K_FL, 32'h0, {29'h0, o_fo});
      if (!o_wr && !o_rd && (o_addr != 0 || o_dout != 0))
        chk("bus_quiet", {o_addr[15:0], o_dout}, 32'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // counts Stall cycles until the selected DUT goes idle, bounded
  task automatic wait_idle(input int max, output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (!o_st) done = 1;
      else n++;
    end
    if (!done) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // one-cycle CALL/RET/RTI pulse; the accept cycle must already stall
  task automatic pulse(input logic c, input logic r, input logic t);
    tick();
    CALL = c; RET = r; RTI = t;
    @(negedge clk);
    chk("accept_stall", {31'h0, o_st}, 32'd1);
    tick();
    CALL = 0; RET = 0; RTI = 0;
  endtask

  task automatic main_seq();
    int n;
    reset_a = 1; reset_b = 1; sel = 0;
    INT = 0; CALL = 0; RET = 0; RTI = 0;
    Target = 0; Return_PC = 0; Flags = 0;
    tick(); tick();
    @(negedge clk);
    chk("reset_stall", {31'h0, o_st}, 32'd0);
    chk("reset_pcload", {31'h0, o_pcl}, 32'd0);
    chk("reset_sp", o_sp, 32'd4095);
    tick(); reset_a = 0;
    @(negedge clk);
    chk("idle_stall", {31'h0, o_st}, 32'd0);

    // CALL from SP=4095
    Return_PC = 32'h0001_0020; Target = 32'd300;
    push_ev(K_WR, 32'd4095, 32'h0001);
    push_ev(K_WR, 32'd4094, 32'h0020);
    push_ev(K_PC, 32'h0, 32'd300);
    pulse(1, 0, 0);
    Return_PC = 32'hDEAD_BEEF; Target = 32'h0;
    wait_idle(20, n);
    chk("call_busy_cycles", n, 32'd2);
    chk("call_sp", o_sp, 32'd4093);
    chk("call_drained", exp_q.size(), 32'd0);

    // RET pops the words stored by the CALL
    push_ev(K_RD, 32'd4094, 32'h0);
    push_ev(K_RD, 32'd4095, 32'h0);
    push_ev(K_PC, 32'h0, 32'h0001_0020);
    pulse(0, 1, 0);
    wait_idle(20, n);
    chk("ret_busy_cycles", n, 32'd3);
    chk("ret_sp", o_sp, 32'd4095);
    chk("ret_drained", exp_q.size(), 32'd0);

    // interrupt entry then RTI
    Flags = 3'b101; Return_PC = 32'd15;
    push_ev(K_WR, 32'd4095, 32'h0000);
    push_ev(K_WR, 32'd4094, 32'h000F);
    push_ev(K_WR, 32'd4093, 32'h0005);
    push_ev(K_PC, 32'h0, 32'h0);
    tick(); INT = 1;
    @(negedge clk);
    chk("int_edge_no_stall", {31'h0, o_st}, 32'd0);
    tick();
    @(negedge clk);
    chk("int_accept_stall", {31'h0, o_st}, 32'd1);
    tick(); Return_PC = 32'h1111_2222; Flags = 3'b000;
    wait_idle(20, n);
    chk("int_busy_cycles", n, 32'd3);
    chk("int_sp", o_sp, 32'd4092);
    tick(); INT = 0;
    push_ev(K_RD, 32'd4093, 32'h0);
    push_ev(K_RD, 32'd4094, 32'h0);
    push_ev(K_RD, 32'd4095, 32'h0);
    push_ev(K_PC, 32'h0, 32'd15);
    push_ev(K_FL, 32'h0, 32'd5);
    pulse(0, 0, 1);
    wait_idle(20, n);
    chk("rti_busy_cycles", n, 32'd4);
    chk("rti_sp", o_sp, 32'd4095);
    chk("rti_drained", exp_q.size(), 32'd0);

    // INT rising during PUSH_HI of a CALL is serviced once, right after
    Return_PC = 32'h0000_1234; Target = 32'h200;
    push_ev(K_WR, 32'd4095, 32'h0000);
    push_ev(K_WR, 32'd4094, 32'h1234);
    push_ev(K_PC, 32'h0, 32'h200);
    push_ev(K_WR, 32'd4093, 32'h0000);
    push_ev(K_WR, 32'd4092, 32'h0ABC);
    push_ev(K_WR, 32'd4091, 32'h0002);
    push_ev(K_PC, 32'h0, 32'h0);
    pulse(1, 0, 0);
    INT = 1; Return_PC = 32'h0000_0ABC; Flags = 3'b010;
    wait_idle(30, n);
    chk("call_int_busy_cycles", n, 32'd6);
    chk("call_int_sp", o_sp, 32'd4090);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_st) chk("int_single_service", {31'h0, o_st}, 32'd0);
    end
    chk("call_int_drained", exp_q.size(), 32'd0);
    tick(); INT = 0;

    // reset landing in POP_HI aborts the RET
    push_ev(K_RD, 32'd4091, 32'h0);
    pulse(0, 1, 0);
    tick(); reset_a = 1;
    @(negedge clk);
    chk("abort_stall_in_reset", {31'h0, o_st}, 32'd0);
    chk("abort_read_in_reset", {31'h0, o_rd}, 32'd0);
    tick(); reset_a = 0;
    @(negedge clk);
    chk("abort_stall_after", {31'h0, o_st}, 32'd0);
    chk("abort_pcload_after", {31'h0, o_pcl}, 32'd0);
    chk("abort_sp_reset", o_sp, 32'd4095);
    tick(); tick();
    chk("abort_drained", exp_q.size(), 32'd0);

    // second instance: SP_RESET=0, increments and wrap-around
    sel = 1;
    tick(); reset_b = 0;
    @(negedge clk);
    chk("b_reset_sp", o_sp, 32'd0);
    push_ev(K_RD, 32'd1, 32'h0);
    push_ev(K_RD, 32'd2, 32'h0);
    push_ev(K_PC, 32'h0, 32'h0);
    pulse(0, 1, 0);
    wait_idle(20, n);
    chk("b_ret_sp", o_sp, 32'd2);
    Return_PC = 32'hCAFE_0007; Flags = 3'b011;
    push_ev(K_WR, 32'd2, 32'hCAFE);
    push_ev(K_WR, 32'd1, 32'h0007);
    push_ev(K_WR, 32'd0, 32'h0003);
    push_ev(K_PC, 32'h0, 32'h0);
    tick(); INT = 1;
    tick(); tick();
    wait_idle(20, n);
    chk("b_int_sp_wrap", o_sp, 32'hFFFF_FFFF);
    tick(); INT = 0;
    push_ev(K_RD, 32'd0, 32'h0);
    push_ev(K_RD, 32'd1, 32'h0);
    push_ev(K_PC, 32'h0, 32'h0007_0003);
    pulse(0, 1, 0);
    wait_idle(20, n);
    chk("b_wrap_ret_sp", o_sp, 32'd1);
    tick(); tick();
    chk("b_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
      begin
        #200000;
        chk("global_timeout", 32'd1, 32'd0);
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter SP_RESET, default 32'd4095: stack pointer value after reset.
REQ-002 SHALL have parameter INT_VECTOR, default 32'd0: PC loaded on interrupt entry.
REQ-003 SHALL have ports as follows; one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- INT  in  1  external interrupt request, level; one service per rising edge seen
- CALL  in  1  one-cycle pulse from EX: CALL instruction
- RET  in  1  one-cycle pulse from EX: RET instruction
- RTI  in  1  one-cycle pulse from EX: RTI instruction
- Target  in  32  CALL target; sampled with CALL
- Return_PC  in  32  PC to save; sampled with CALL, or on interrupt accept
- Flags  in  3  {NF,CF,ZF}; sampled on interrupt accept
- Mem_Data_In  in  16  read data; valid the cycle after Mem_Read
- Mem_Address  out  32  memory word address
- Mem_Data_Out  out  16  write data
- Mem_Read, Mem_Write  out  1 each  memory strobes; never both high
- Stall  out  1  freeze IF/ID and ID/EX; insert bubble into EX/MEM
- PC_Load  out  1  one-cycle strobe: PC <= PC_Out
- PC_Out  out  32  new PC value
- Flags_Load  out  1  one-cycle strobe: flag register <= Flags_Out
- Flags_Out  out  3  restored flags
- Stack_Pointer_Out  out  32  current SP register value

Function
REQ-004 SHALL use states IDLE, PUSH_HI, PUSH_LO, PUSH_F, POP_F, POP_LO, POP_HI and FINISH.
REQ-005 SHALL store a push at Mem_Address=SP with Mem_Write=1, then decrement SP.
REQ-006 SHALL perform a pop by incrementing SP and setting Mem_Address to the incremented SP with Mem_Read=1.
REQ-007 SHALL treat SP arithmetic as modulo 2^32: wrap-around is silent, with no overflow or underflow flag.
REQ-008 SHALL accept requests in IDLE by priority CALL/RET/RTI, then INT. CALL/RET/RTI are mutually exclusive by decode; if more than one is high, CALL wins, then RET.
REQ-009 SHALL set an internal int_pending bit on any INT rising edge. The bit is cleared on interrupt accept. An INT edge during a busy sequence is serviced on the first IDLE cycle after that sequence.
REQ-010 CALL sequence SHALL be: IDLE -> PUSH_HI (write Return_PC[31:16]) -> PUSH_LO (write Return_PC[15:0], PC_Load=1, PC_Out=Target) -> IDLE; 2 busy cycles.
REQ-011 INT sequence SHALL be: IDLE -> PUSH_HI -> PUSH_LO -> PUSH_F (write {13'b0,Flags}, PC_Load=1, PC_Out=INT_VECTOR) -> IDLE; 3 busy cycles.
REQ-012 RET sequence SHALL be: IDLE -> POP_LO -> POP_HI -> FINISH (PC_Load=1, PC_Out={hi,lo}) -> IDLE. The lo word is captured in POP_HI and the hi word in FINISH.
REQ-013 RTI sequence SHALL be: IDLE -> POP_F -> POP_LO -> POP_HI -> FINISH (PC_Load=1, Flags_Load=1, Flags_Out=popped[2:0]) -> IDLE.
REQ-014 SHALL drive Stall = (state!=IDLE) OR (state==IDLE AND a request is accepted this cycle).
REQ-015 SHALL register Return_PC, Target and Flags at accept, so input changes during the sequence have no effect.
REQ-016 SHALL ignore CALL/RET/RTI pulses arriving while state!=IDLE; pipeline Stall guarantees none are issued.
REQ-017 SHALL hold PC_Load and Flags_Load low except in the cycles named above. Mem_Read and Mem_Write SHALL be 0 in IDLE and FINISH.
REQ-018 SHALL keep Mem_Address and Mem_Data_Out at 0 when no strobe is active.

Reset
REQ-019 SHALL, on reset=1 at a rising edge, set: state=IDLE, SP=SP_RESET, int_pending=0, captured registers=0.
REQ-020 SHALL hold all strobes, Stall, PC_Out and Flags_Out at 0 while reset is high.
REQ-021 SHALL abort any sequence in progress on reset, with no further memory access. Partial stack contents are not restored.

Verification
REQ-022 Bench SHALL cover: CALL with Return_PC=32'h0001_0020, Target=32'd300, SP=4095 -> writes 16'h0001@4095 then 16'h0020@4094; PC_Load with PC_Out=300 in the 2nd cycle; SP=4093.
REQ-023 Bench SHALL cover: RET following that CALL, with memory returning the stored words -> reads @4094 then @4095; PC_Out=32'h0001_0020 in FINISH; SP=4095; 3 Stall cycles.
REQ-024 Bench SHALL cover: INT with Flags=3'b101, Return_PC=15, then RTI -> writes @4095,4094 and 16'h0005@4093; PC_Out=0; the RTI then gives Flags_Out=3'b101, PC_Out=15 and SP=4095.
REQ-025 Bench SHALL cover: INT rising in the PUSH_HI cycle of a CALL -> CALL completes, then the INT sequence starts on the next IDLE cycle; exactly one interrupt service.
REQ-026 Bench SHALL cover: SP_RESET=0, then RET -> reads address 1 and address 2 (increment from 0), SP=2; with SP at 32'hFFFF_FFFF, a RET reads address 0 and wraps.
REQ-027 Bench SHALL cover: reset asserted in POP_HI -> next cycle IDLE, SP=SP_RESET, Stall=0, and no PC_Load.
